// File: rtl/if_prefetch_queue_pkg.sv
// Shared constants and helpers for the fetch stage prefetch queue.
// Bus layouts: br_bus = {br_taken, br_target}, fs_to_ds_bus = {pc, inst}.
package if_prefetch_queue_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int ILEN_DEFAULT  = 32;
  localparam int DEPTH_DEFAULT = 4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  // Byte stride between sequential fetches.
  localparam int INST_BYTES = 4;

  function automatic int fs_to_ds_bus_wd(input int xlen, input int ilen);
    return xlen + ilen;
  endfunction

  function automatic int br_bus_wd(input int xlen);
    return 1 + xlen;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/if_prefetch_queue_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} pairs, with a single-cycle flush.
// The head entry is read straight from registered storage.
module if_prefetch_queue_fetch_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // The credit rule upstream guarantees these never fire.
  assert property (@(posedge clk) disable iff (reset) (push && !pop && !flush) |-> !full);
  assert property (@(posedge clk) disable iff (reset) (pop && !flush) |-> !empty);

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction fetch stage: issues reads to inst_sram and queues the returned
// instructions for ID, with branch redirect squash and credit-limited issue.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter int               ILEN     = ILEN_DEFAULT,
  parameter int               DEPTH    = DEPTH_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_sram_en_toif,
  input  logic [XLEN:0]         br_bus,
  input  logic                  ds_allowin,
  output logic                  fs_to_ds_valid,
  output logic [XLEN+ILEN-1:0]  fs_to_ds_bus,
  output logic                  inst_sram_en,
  output logic [XLEN-1:0]       inst_sram_addr,
  input  logic [ILEN-1:0]       inst_sram_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("if_prefetch_queue: DEPTH must be a power of 2 and >= 2");
  end

  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] addr;
  logic            req_v_q;
  logic [XLEN-1:0] req_pc_q;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic [CW:0]     credit_limit;
  logic            fifo_full;
  logic            fifo_empty;

  assign br_taken  = br_bus[XLEN];
  assign br_target = br_bus[XLEN-1:0];
  assign addr      = br_taken ? br_target : fetch_pc;

  // A redirect hides the (wrong-path) head this cycle, so nothing pops.
  assign fs_to_ds_valid = (count != '0) && !br_taken;
  assign pop            = fs_to_ds_valid && ds_allowin;

  // Entries held plus one in flight must fit, counting the slot freed by a pop.
  assign credit_used  = {1'b0, count} + (CW+1)'(req_v_q);
  assign credit_limit = (CW+1)'(DEPTH) + (CW+1)'(pop);

  assign inst_sram_en   = !reset && inst_sram_en_toif && (br_taken || (credit_used < credit_limit));
  assign inst_sram_addr = addr;

  // Data returning in a redirect cycle belongs to a squashed request.
  assign push = req_v_q && !br_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_v_q  <= 1'b0;
      req_pc_q <= '0;
    end else begin
      req_v_q  <= inst_sram_en;
      req_pc_q <= addr;
      if (inst_sram_en) begin
        fetch_pc <= addr + XLEN'(INST_BYTES);
      end
    end
  end

  if_prefetch_queue_fetch_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (br_taken),
    .wdata ({req_pc_q, inst_sram_rdata}),
    .head  (fs_to_ds_bus),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
